// File: rtl/axis_block_serializer.sv
// axis_block_serializer: captures a DATA_WIDTH-bit block on an AXI-Stream slave
// port and replays it one byte per handshake on an 8-bit AXI-Stream master port.
// Define SERIALIZER_CHECKSUM_EN to append one XOR checksum byte to each frame.
module axis_block_serializer #(
    parameter int DATA_WIDTH = 96,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W     = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 16) begin : g_bad_width
        $error("axis_block_serializer: DATA_WIDTH must be a multiple of 8 and >= 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef SERIALIZER_CHECKSUM_EN
        CSUM = 2'd2,
`endif
        SEND = 2'd1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [DATA_WIDTH-1:0]   hold;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [7:0]              csum;
`endif

    // Byte idx of a block in transmit order.
    function automatic logic [7:0] pick_byte(input logic [DATA_WIDTH-1:0] blk,
                                             input logic [CNT_W-1:0] idx);
        int pos;
        pos = MSB_FIRST ? (NUM_BYTES - 1 - int'(idx)) : int'(idx);
        return blk[pos*8 +: 8];
    endfunction

    assign cnt_nxt       = cnt + 1'b1;
    assign s_axis_tready = (state == IDLE);
    assign busy          = (state != IDLE);

    // Frame FSM; output byte, valid and last are registered so they stay put under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hold          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= 8'h00;
`ifdef SERIALIZER_CHECKSUM_EN
            csum          <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        hold          <= s_axis_tdata;
                        cnt           <= '0;
                        state         <= SEND;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tdata  <= pick_byte(s_axis_tdata, '0);
`ifdef SERIALIZER_CHECKSUM_EN
                        csum          <= 8'h00;
`endif
                    end
                end
                SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (cnt == LAST_IDX) begin
`ifdef SERIALIZER_CHECKSUM_EN
                            // Fold the final data byte in on the way to the checksum beat.
                            state         <= CSUM;
                            m_axis_tdata  <= csum ^ m_axis_tdata;
                            m_axis_tlast  <= 1'b1;
`else
                            state         <= IDLE;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
`endif
                        end else begin
                            cnt          <= cnt_nxt;
                            m_axis_tdata <= pick_byte(hold, cnt_nxt);
`ifdef SERIALIZER_CHECKSUM_EN
                            m_axis_tlast <= 1'b0;
`else
                            m_axis_tlast <= (cnt_nxt == LAST_IDX);
`endif
                        end
`ifdef SERIALIZER_CHECKSUM_EN
                        csum <= csum ^ m_axis_tdata;
`endif
                    end
                end
`ifdef SERIALIZER_CHECKSUM_EN
                CSUM: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        state         <= IDLE;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state         <= IDLE;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_block_serializer.sv
// Bench for axis_block_serializer: MSB-first and LSB-first instances share one
// stimulus; a byte-level scoreboard per instance is filled at each input capture.
module tb_axis_block_serializer;
    localparam int DW = 96;
    localparam int NB = DW / 8;
`ifdef SERIALIZER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam int FL = NB + (CS ? 1 : 0);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          m_tready = 1'b0;
    logic          s_tready0, s_tready1, m_tvalid0, m_tvalid1, m_tlast0, m_tlast1, busy0, busy1;
    logic [7:0]    m_tdata0, m_tdata1;

    always #5 clk = ~clk;

    axis_block_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast0), .busy(busy0));

    axis_block_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast1), .busy(busy1));

    typedef struct packed { logic [7:0] data; logic last; } beat_t;
    typedef struct { logic [DW-1:0] d; logic [7:0] first_msb; logic [7:0] last_msb; bit stalls; } vec_t;

    beat_t      q0[$], q1[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, caps = 0, hs0 = 0, nb0 = 0, nb1 = 0;
    int         rise_cyc = 0, cap_cyc = 0, last_hs_cyc = 0;
    bit         stall0 = 0, stall1 = 0, vprev = 0;
    logic [7:0] pd0 = '0, pd1 = '0, first0 = '0, first1 = '0;
    logic       pl0 = 0, pl1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [DW-1:0] b, input int i, input bit msb);
        logic [DW-1:0] t;
        t = msb ? (b >> (8 * (NB - 1 - i))) : (b >> (8 * i));
        return t[7:0];
    endfunction

    task automatic push_frame(input logic [DW-1:0] b);
        beat_t e;
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < NB; i++) begin
            e.last = (i == NB - 1) && !CS;
            e.data = ref_byte(b, i, 1'b1); q0.push_back(e);
            e.data = ref_byte(b, i, 1'b0); q1.push_back(e);
            x ^= e.data;
        end
        if (CS) begin
            e.data = x; e.last = 1'b1;
            q0.push_back(e); q1.push_back(e);
        end
    endtask

    // Called right after a negedge once inputs are set; outputs are stable until the next posedge.
    task automatic observe();
        beat_t e;
        #1;
        cyc++;
        chk("valid_in_idle0", {31'd0, m_tvalid0 & s_tready0}, 0);
        chk("valid_in_idle1", {31'd0, m_tvalid1 & s_tready1}, 0);
        if (stall0) begin chk("stall_data0", m_tdata0, pd0); chk("stall_last0", m_tlast0, pl0); end
        if (stall1) begin chk("stall_data1", m_tdata1, pd1); chk("stall_last1", m_tlast1, pl1); end
        if (m_tvalid0 && !vprev) rise_cyc = cyc;
        vprev = m_tvalid0;
        if (m_tvalid0 && m_tready) begin
            chk("q0_has_entry", {31'd0, q0.size() > 0}, 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("data0", m_tdata0, e.data); chk("last0", m_tlast0, e.last);
            end
            if (nb0 == 0) first0 = m_tdata0;
            hs0++;
            if (m_tlast0) begin nb0 = 0; last_hs_cyc = cyc; end else nb0++;
        end
        if (m_tvalid1 && m_tready) begin
            chk("q1_has_entry", {31'd0, q1.size() > 0}, 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("data1", m_tdata1, e.data); chk("last1", m_tlast1, e.last);
            end
            if (nb1 == 0) first1 = m_tdata1;
            if (m_tlast1) nb1 = 0; else nb1++;
        end
        stall0 = m_tvalid0 && !m_tready; pd0 = m_tdata0; pl0 = m_tlast0;
        stall1 = m_tvalid1 && !m_tready; pd1 = m_tdata1; pl1 = m_tlast1;
        if (s_tvalid && s_tready0) begin
            push_frame(s_tdata); cap_cyc = cyc; caps++;
        end
    endtask

    task automatic drain(input bit stalls);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(negedge clk);
            s_tvalid = 1'b0; s_tdata = {3{$urandom}};
            m_tready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            observe(); n++;
        end
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
    endtask

    task automatic run_block(input logic [DW-1:0] d, input bit stalls, output int lat, output int span);
        int c0, n;
        c0 = caps; n = 0;
        while (caps == c0 && n < 50) begin
            @(negedge clk);
            s_tdata = d; s_tvalid = 1'b1;
            m_tready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            observe(); n++;
        end
        chk("block_captured", caps - c0, 1);
        drain(stalls);
        lat  = rise_cyc - cap_cyc;
        span = last_hs_cyc - rise_cyc + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int lat, span, c0, n, gap, h;
        tbl[0] = '{96'h0123456789ABCDEF11112222, 8'h01, 8'h22, 1'b0};
        tbl[1] = '{96'h000000000000000000000001, 8'h00, 8'h01, 1'b0};
        tbl[2] = '{96'hA5A5A5A5A5A5A5A5A5A5A5A5, 8'hA5, 8'hA5, 1'b1};
        tbl[3] = '{96'h8000000000000000000000FF, 8'h80, 8'hFF, 1'b1};
        tbl[4] = '{96'h0123456789ABCDEF11112222, 8'h01, 8'h22, 1'b1};

        // Reset state
        #1;
        chk("rst_tvalid", {m_tvalid1, m_tvalid0}, 0);
        chk("rst_tlast", {m_tlast1, m_tlast0}, 0);
        chk("rst_tdata", {m_tdata1, m_tdata0}, 0);
        chk("rst_busy", {busy1, busy0}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_tready", {s_tready1, s_tready0}, 2'b11);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            run_block(tbl[i].d, tbl[i].stalls, lat, span);
            chk($sformatf("v%0d_first_msb", i), first0, tbl[i].first_msb);
            chk($sformatf("v%0d_first_lsb", i), first1, tbl[i].last_msb);
            chk($sformatf("v%0d_latency", i), lat, 1);
            if (!tbl[i].stalls) chk($sformatf("v%0d_span", i), span, FL);
        end

        // Back-to-back offers with tvalid held high
        c0 = caps; n = 0; gap = -1;
        while (caps < c0 + 2 && n < 200) begin
            @(negedge clk);
            s_tvalid = 1'b1; m_tready = 1'b1;
            s_tdata = (caps == c0) ? 96'h0123456789ABCDEF11112222 : 96'hFEDCBA9876543210CAFEF00D;
            observe(); n++;
            if (caps == c0 + 2) gap = cap_cyc - last_hs_cyc;
        end
        chk("b2b_captures", caps - c0, 2);
        chk("b2b_gap", gap, 1);
        drain(1'b0);
        chk("b2b_first_msb", first0, 8'hFE);
        chk("b2b_first_lsb", first1, 8'h0D);

        // Reset after the 5th byte handshake
        c0 = caps; n = 0;
        while (caps == c0 && n < 50) begin
            @(negedge clk);
            s_tdata = 96'h112233445566778899AABBCC; s_tvalid = 1'b1; m_tready = 1'b1;
            observe(); n++;
        end
        h = hs0; n = 0;
        while (hs0 < h + 5 && n < 50) begin
            @(negedge clk);
            s_tvalid = 1'b0; m_tready = 1'b1;
            observe(); n++;
        end
        chk("pre_reset_handshakes", hs0 - h, 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", {m_tvalid1, m_tvalid0}, 0);
        chk("mid_rst_busy", {busy1, busy0}, 0);
        chk("mid_rst_tdata", {m_tdata1, m_tdata0}, 0);
        chk("mid_rst_tlast", {m_tlast1, m_tlast0}, 0);
        q0.delete(); q1.delete();
        stall0 = 0; stall1 = 0; vprev = 0; nb0 = 0; nb1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        h = hs0;
        repeat (6) begin
            @(negedge clk);
            s_tvalid = 1'b0; m_tready = 1'b1;
            observe();
        end
        chk("no_bytes_after_reset", hs0 - h, 0);
        run_block(96'hCAFEBABE0000000012345678, 1'b0, lat, span);
        chk("post_rst_first_msb", first0, 8'hCA);
        chk("post_rst_first_lsb", first1, 8'h78);
        chk("post_rst_span", span, FL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_block_serializer.md
AXIS_BLOCK_SERIALIZER -- requirements
Module: axis_block_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 96, is the input block width in bits and SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter MSB_FIRST, default 1: when 1 the most-significant byte is sent first; when 0 the least-significant byte is sent first.
REQ-003 clk  input  1  is the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-005 s_axis_tdata  input  DATA_WIDTH  is the cipher block to serialize.
REQ-006 s_axis_tvalid  input  1  indicates the input block is valid.
REQ-007 s_axis_tready  output  1  indicates the block can accept an input.
REQ-008 m_axis_tdata  output  8  is the byte presented to the UART transmitter.
REQ-009 m_axis_tvalid  output  1  indicates the output byte is valid.
REQ-010 m_axis_tready  input  1  is backpressure from the UART.
REQ-011 m_axis_tlast  output  1  marks the final byte of a frame.
REQ-012 busy  output  1  is high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement states IDLE, SEND and CSUM; CSUM is present only with the checksum feature.
REQ-014 s_axis_tready SHALL equal (state==IDLE); in IDLE m_axis_tvalid SHALL be 0.
REQ-015 On an input handshake in IDLE, the block SHALL capture s_axis_tdata into a holding register, clear byte counter cnt to 0 and enter SEND on the next edge.
REQ-016 m_axis_tvalid SHALL rise on the first clock edge after the input handshake (latency 1 cycle) and remain high through SEND/CSUM.
REQ-017 In SEND, m_axis_tdata SHALL be byte cnt of the held block, ordered per MSB_FIRST.
REQ-018 An output handshake SHALL be m_axis_tvalid&&m_axis_tready; each handshake in SEND SHALL advance cnt by 1.
REQ-019 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and cnt SHALL hold stable.
REQ-020 Handshake at cnt==DATA_WIDTH/8-1 SHALL go to IDLE (feature off) or CSUM (feature on); cnt SHALL never wrap beyond DATA_WIDTH/8-1.
REQ-021 m_axis_tlast SHALL be 1 only on the final byte of a frame: last data byte (feature off) or the checksum byte (feature on).
REQ-022 Throughput SHALL be one byte per cycle with m_axis_tready held high; exactly one idle cycle (s_axis_tready=1, m_axis_tvalid=0) separates consecutive frames.
REQ-023 Input held valid while s_axis_tready=0 SHALL not be captured and SHALL not alter the held block.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, cnt 0, holding register 0, checksum accumulator 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 8'h00, busy 0; s_axis_tready SHALL read 1 once rst_n is high.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; no remaining bytes are emitted after release.

Configuration
REQ-026 Macro SERIALIZER_CHECKSUM_EN defined: after the last data byte the block SHALL enter CSUM and emit one extra byte equal to the XOR of all DATA_WIDTH/8 data bytes, with m_axis_tlast=1, then return to IDLE on its handshake.
REQ-027 Macro undefined: no CSUM state or accumulator exists; frame length is exactly DATA_WIDTH/8 bytes.

Verification
REQ-028 Default params, macro off, tdata=96'h0123456789ABCDEF11112222, tready=1 -> bytes 01,23,45,67,89,AB,CD,EF,11,11,22,22 on 12 consecutive cycles, tlast only on final 22.
REQ-029 Macro on, tdata=96'h000000000000000000000001 -> 12 bytes 00..00,01 then checksum 01 with tlast=1; same vector with MSB_FIRST=0 -> 01,00x11, checksum 01.
REQ-030 Random m_axis_tready stalls during a frame -> byte sequence unchanged, tdata/tlast stable during every stall, no byte duplicated or dropped.
REQ-031 Two blocks offered back-to-back with s_axis_tvalid held high -> second captured only after first frame's tlast handshake plus one IDLE cycle; second block value unaffected by holding.
REQ-032 rst_n pulsed low after 5th byte handshake -> m_axis_tvalid 0 asynchronously, no further bytes; next block after release serializes fully from byte 0.
